// File: rtl/noname_pkg.sv
// Shared definitions for the memory arbiter: FSM state encoding and bus constants.
package noname_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_GNT_I = 2'd1,
        ARB_GNT_D = 2'd2
    } arb_state_e;

    localparam int         DEFAULT_TIMEOUT = 255;
    localparam logic [3:0] SEL_ALL         = 4'hF;

endpackage

// File: rtl/bus_watchdog.sv
// Counts cycles a bus grant has been held; pulses expired_o when the limit is reached.
module bus_watchdog
    import noname_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic run_i,
    output logic expired_o
);

    // A zero TIMEOUT still needs a one-bit counter to keep the declaration legal.
    localparam int              CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);

    logic [CNT_W-1:0] r_count;

    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            r_count <= '0;
        end else if (run_i && (r_count != LIMIT)) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign expired_o = (TIMEOUT != 0) && run_i && (r_count == LIMIT);

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one Wishbone B4 classic master between fetch and load/store.
// DATA_W must be 32; byte-lane selects are fixed at four bits.
module mem_arbiter
    import noname_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic              clk_i,
    input  logic              rst_i,

    input  logic              iport_cyc_i,
    input  logic              iport_stb_i,
    input  logic [ADDR_W-1:0] iport_addr_i,
    output logic [DATA_W-1:0] iport_dat_o,
    output logic              iport_ack_o,
    output logic              iport_err_o,

    input  logic              dport_cyc_i,
    input  logic              dport_stb_i,
    input  logic              dport_we_i,
    input  logic [ADDR_W-1:0] dport_addr_i,
    input  logic [DATA_W-1:0] dport_dat_i,
    input  logic [3:0]        dport_sel_i,
    output logic [DATA_W-1:0] dport_dat_o,
    output logic              dport_ack_o,
    output logic              dport_err_o,

    output logic              wbm_cyc_o,
    output logic              wbm_stb_o,
    output logic              wbm_we_o,
    output logic [ADDR_W-1:0] wbm_addr_o,
    output logic [DATA_W-1:0] wbm_dat_o,
    output logic [3:0]        wbm_sel_o,
    input  logic [DATA_W-1:0] wbm_dat_i,
    input  logic              wbm_ack_i,
    input  logic              wbm_err_i
);

    arb_state_e r_state;
    logic       r_last_d;

    logic w_i_pend, w_d_pend;
    logic w_own_i, w_own_d, w_idle;
    logic w_live, w_expired, w_release;
    logic w_bus_ack, w_bus_err;

    assign w_i_pend = iport_cyc_i & iport_stb_i;
    assign w_d_pend = dport_cyc_i & dport_stb_i;
    assign w_own_i  = (r_state == ARB_GNT_I);
    assign w_own_d  = (r_state == ARB_GNT_D);
    assign w_idle   = (r_state == ARB_IDLE);

    // The owner dropping cyc is an abort: nothing is forwarded and the grant is released.
    assign w_live    = (w_own_i & iport_cyc_i) | (w_own_d & dport_cyc_i);
    assign w_bus_ack = w_live & wbm_ack_i & ~wbm_err_i;
    assign w_bus_err = w_live & (wbm_err_i | (w_expired & ~wbm_ack_i));
    assign w_release = ~w_live | wbm_ack_i | wbm_err_i | w_expired;

    bus_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clear_i   (w_idle),
        .run_i     (~w_idle),
        .expired_o (w_expired)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state  <= ARB_IDLE;
            r_last_d <= 1'b1;
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    if (w_i_pend && (!w_d_pend || r_last_d)) begin
                        r_state  <= ARB_GNT_I;
                        r_last_d <= 1'b0;
                    end else if (w_d_pend) begin
                        r_state  <= ARB_GNT_D;
                        r_last_d <= 1'b1;
                    end
                end
                default: begin
                    if (w_release) r_state <= ARB_IDLE;
                end
            endcase
        end
    end

    // NOTE: every output gets a default first so no path through the case infers a latch.
    always_comb begin
        wbm_cyc_o  = 1'b0;
        wbm_stb_o  = 1'b0;
        wbm_we_o   = 1'b0;
        wbm_addr_o = '0;
        wbm_dat_o  = '0;
        wbm_sel_o  = '0;
        case (r_state)
            ARB_GNT_I: begin
                wbm_cyc_o  = iport_cyc_i;
                wbm_stb_o  = iport_cyc_i & iport_stb_i;
                wbm_addr_o = iport_addr_i;
                wbm_sel_o  = SEL_ALL;
            end
            ARB_GNT_D: begin
                wbm_cyc_o  = dport_cyc_i;
                wbm_stb_o  = dport_cyc_i & dport_stb_i;
                wbm_we_o   = dport_we_i;
                wbm_addr_o = dport_addr_i;
                wbm_dat_o  = dport_dat_i;
                wbm_sel_o  = dport_sel_i;
            end
            default: ;
        endcase
    end

    assign iport_ack_o = w_own_i & w_bus_ack;
    assign iport_err_o = w_own_i & w_bus_err;
    assign dport_ack_o = w_own_d & w_bus_ack;
    assign dport_err_o = w_own_d & w_bus_err;

    // Read data is passed through unqualified; only ack marks it valid.
    assign iport_dat_o = wbm_dat_i;
    assign dport_dat_o = wbm_dat_i;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table, directed corner cases, random vs. model.
module tb_mem_arbiter;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        ic, istb, dc, dstb, dwe;
    logic [31:0] ia, da, dd, rd;
    logic [3:0]  ds;
    logic        ack, err;
    logic [31:0] i_dat, d_dat, w_addr, w_wd;
    logic        i_ack, i_err, d_ack, d_err;
    logic        w_cyc, w_stb, w_we;
    logic [3:0]  w_sel;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mem_arbiter #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .TIMEOUT (TO)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .iport_cyc_i  (ic),
        .iport_stb_i  (istb),
        .iport_addr_i (ia),
        .iport_dat_o  (i_dat),
        .iport_ack_o  (i_ack),
        .iport_err_o  (i_err),
        .dport_cyc_i  (dc),
        .dport_stb_i  (dstb),
        .dport_we_i   (dwe),
        .dport_addr_i (da),
        .dport_dat_i  (dd),
        .dport_sel_i  (ds),
        .dport_dat_o  (d_dat),
        .dport_ack_o  (d_ack),
        .dport_err_o  (d_err),
        .wbm_cyc_o    (w_cyc),
        .wbm_stb_o    (w_stb),
        .wbm_we_o     (w_we),
        .wbm_addr_o   (w_addr),
        .wbm_dat_o    (w_wd),
        .wbm_sel_o    (w_sel),
        .wbm_dat_i    (rd),
        .wbm_ack_i    (ack),
        .wbm_err_i    (err)
    );

    // Record fields are all 32 bits wide so the table can use plain literals.
    typedef struct {
        logic [31:0] rst, ic, ia, dc, dwe, da, dd, ds, ack, err, rd;
        logic [31:0] e_cyc, e_we, e_addr, e_sel, e_wd, e_ia, e_ie, e_da, e_de;
    } vec_t;

    vec_t vecs [14];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [74:0] dut_out();
        return {w_cyc, w_stb, w_we, w_sel, w_addr, w_wd, i_ack, i_err, d_ack, d_err};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        ic = 0; istb = 0; ia = '0;
        dc = 0; dstb = 0; dwe = 0; da = '0; dd = '0; ds = '0;
        ack = 0; err = 0; rd = '0;
    endtask

    task automatic do_reset();
        drive_idle();
        rst = 1;
        tick();
        rst = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1;
        drive_idle();
        tick();
        tick();
        rst = 0;

        //            rst ic ia       dc we da      dd       ds  ack err rd            cyc we addr    sel wd      ia ie da de
        vecs[0]  = '{0, 1, 'h100, 0, 0, 0,      0,       0,  0, 0, 0,            0, 0, 0,      0,  0,      0, 0, 0, 0};
        vecs[1]  = '{0, 1, 'h100, 0, 0, 0,      0,       0,  0, 0, 0,            1, 0, 'h100,  'hF, 0,     0, 0, 0, 0};
        vecs[2]  = '{0, 1, 'h100, 0, 0, 0,      0,       0,  1, 0, 'hDEADBEEF,   1, 0, 'h100,  'hF, 0,     1, 0, 0, 0};
        vecs[3]  = '{0, 0, 0,     0, 0, 0,      0,       0,  0, 0, 0,            0, 0, 0,      0,  0,      0, 0, 0, 0};
        vecs[4]  = '{1, 0, 0,     0, 0, 0,      0,       0,  0, 0, 0,            0, 0, 0,      0,  0,      0, 0, 0, 0};
        vecs[5]  = '{0, 1, 'h200, 1, 1, 'h300,  'h1234,  3,  0, 0, 0,            0, 0, 0,      0,  0,      0, 0, 0, 0};
        vecs[6]  = '{0, 1, 'h200, 1, 1, 'h300,  'h1234,  3,  1, 0, 'hCAFE0001,   1, 0, 'h200,  'hF, 0,     1, 0, 0, 0};
        vecs[7]  = '{0, 1, 'h204, 1, 1, 'h300,  'h1234,  3,  0, 0, 0,            0, 0, 0,      0,  0,      0, 0, 0, 0};
        vecs[8]  = '{0, 1, 'h204, 1, 1, 'h300,  'h1234,  3,  1, 0, 'hCAFE0002,   1, 1, 'h300,  3,  'h1234, 0, 0, 1, 0};
        vecs[9]  = '{0, 1, 'h204, 1, 0, 'h304,  0,       'hF, 0, 0, 0,           0, 0, 0,      0,  0,      0, 0, 0, 0};
        vecs[10] = '{0, 1, 'h204, 1, 0, 'h304,  0,       'hF, 1, 0, 'hCAFE0003,  1, 0, 'h204,  'hF, 0,     1, 0, 0, 0};
        vecs[11] = '{0, 0, 0,     1, 0, 'h304,  0,       'hF, 0, 0, 0,           0, 0, 0,      0,  0,      0, 0, 0, 0};
        vecs[12] = '{0, 0, 0,     1, 0, 'h304,  0,       'hF, 1, 1, 'hCAFE0004,  1, 0, 'h304,  'hF, 0,     0, 0, 0, 1};
        vecs[13] = '{0, 0, 0,     0, 0, 0,      0,       0,  0, 0, 0,            0, 0, 0,      0,  0,      0, 0, 0, 0};

        // Reset state before any request.
        @(negedge clk);
        check("reset_outputs", 128'(dut_out()), 128'(0));
        tick();

        for (int k = 0; k < 14; k++) begin
            rst = vecs[k].rst[0];
            ic = vecs[k].ic[0]; istb = vecs[k].ic[0]; ia = vecs[k].ia;
            dc = vecs[k].dc[0]; dstb = vecs[k].dc[0]; dwe = vecs[k].dwe[0];
            da = vecs[k].da; dd = vecs[k].dd; ds = vecs[k].ds[3:0];
            ack = vecs[k].ack[0]; err = vecs[k].err[0]; rd = vecs[k].rd;
            @(negedge clk);
            check($sformatf("vec%0d_outputs", k), 128'(dut_out()),
                  128'({vecs[k].e_cyc[0], vecs[k].e_cyc[0], vecs[k].e_we[0], vecs[k].e_sel[3:0],
                        vecs[k].e_addr, vecs[k].e_wd, vecs[k].e_ia[0], vecs[k].e_ie[0],
                        vecs[k].e_da[0], vecs[k].e_de[0]}));
            check($sformatf("vec%0d_rdata", k), 128'({i_dat, d_dat}), 128'({vecs[k].rd, vecs[k].rd}));
            tick();
        end

        // Watchdog: store with no ack errors in grant cycle + TO.
        do_reset();
        dc = 1; dstb = 1; dwe = 1; da = 'h400; dd = 'h55; ds = 4'hF;
        @(negedge clk);
        check("wd_idle_cyc", 128'(w_cyc), 128'(0));
        tick();
        for (int k = 0; k < TO; k++) begin
            @(negedge clk);
            check($sformatf("wd_hold%0d_cyc_err", k), 128'({w_cyc, d_err}), 128'({1'b1, 1'b0}));
            tick();
        end
        @(negedge clk);
        check("wd_expire_err", 128'({d_err, d_ack, i_err}), 128'({1'b1, 1'b0, 1'b0}));
        tick();
        dc = 0; dstb = 0;
        ic = 1; istb = 1; ia = 'h500;
        @(negedge clk);
        check("wd_after_cyc_low", 128'({w_cyc, d_err}), 128'(0));
        tick();
        ack = 1; rd = 'h600D;
        @(negedge clk);
        check("wd_then_fetch", 128'({w_cyc, w_addr, i_ack, i_err}), 128'({1'b1, 32'h500, 1'b1, 1'b0}));
        tick();
        drive_idle();
        tick();

        // Ack arriving in the exact timeout cycle wins over the watchdog.
        dc = 1; dstb = 1; dwe = 0; da = 'h440; ds = 4'hF;
        tick();
        for (int k = 0; k < TO; k++) tick();
        ack = 1;
        @(negedge clk);
        check("race_ack_wins", 128'({d_ack, d_err}), 128'({1'b1, 1'b0}));
        tick();
        drive_idle();
        tick();

        // Abort: dropping cyc releases the bus in the same cycle; a late ack is ignored.
        dc = 1; dstb = 1; dwe = 1; da = 'h480; dd = 'h77; ds = 4'h1;
        tick();
        @(negedge clk);
        check("abort_granted", 128'({w_cyc, w_stb, w_addr}), 128'({1'b1, 1'b1, 32'h480}));
        tick();
        dc = 0; dstb = 0;
        @(negedge clk);
        check("abort_same_cycle", 128'({w_cyc, w_stb, d_ack, d_err}), 128'(0));
        tick();
        ack = 1;
        @(negedge clk);
        check("abort_late_ack", 128'({d_ack, i_ack, d_err, i_err}), 128'(0));
        tick();
        drive_idle();
        tick();

        // Reset during a data grant, with a slave ack pending afterwards.
        dc = 1; dstb = 1; dwe = 1; da = 'h600; dd = 'h99; ds = 4'h3;
        tick();
        @(negedge clk);
        check("rstmid_granted", 128'({w_cyc, w_we, w_addr}), 128'({1'b1, 1'b1, 32'h600}));
        tick();
        rst = 1;
        tick();
        rst = 0; ack = 1; ic = 1; istb = 1; ia = 'h700;
        @(negedge clk);
        check("rstmid_outputs_zero", 128'(dut_out()), 128'(0));
        tick();
        ack = 0;
        @(negedge clk);
        check("rstmid_tie_iport", 128'({w_cyc, w_we, w_addr}), 128'({1'b1, 1'b0, 32'h700}));
        tick();
        ack = 1;
        @(negedge clk);
        check("rstmid_fetch_ack", 128'({i_ack, d_ack}), 128'({1'b1, 1'b0}));
        tick();
        drive_idle();
        tick();

        // Random traffic against a bus-ownership model.
        begin
            int          owner;   // 0 = nobody, 1 = fetch, 2 = load/store
            bit          last_d;
            int          age;
            bit          i_act, d_act, i_fin, d_fin;
            logic [31:0] ia_r, da_r, dd_r;
            logic [3:0]  ds_r;
            bit          dwe_r;
            do_reset();
            owner = 0; last_d = 1; age = 0;
            i_act = 0; d_act = 0; i_fin = 0; d_fin = 0;
            ia_r = '0; da_r = '0; dd_r = '0; ds_r = '0; dwe_r = 0;
            for (int c = 0; c < 2000; c++) begin
                logic [74:0] exp;
                bit          live, tmo, done, oa, oe;

                if (i_act && (i_fin || $urandom_range(0, 99) < 3)) i_act = 0;
                else if (!i_act && $urandom_range(0, 99) < 40) begin
                    i_act = 1; ia_r = $urandom;
                end
                if (d_act && (d_fin || $urandom_range(0, 99) < 3)) d_act = 0;
                else if (!d_act && $urandom_range(0, 99) < 40) begin
                    d_act = 1; da_r = $urandom; dd_r = $urandom;
                    ds_r = 4'($urandom); dwe_r = 1'($urandom);
                end
                ic = i_act; istb = i_act; ia = ia_r;
                dc = d_act; dstb = d_act; da = da_r; dd = dd_r; ds = ds_r; dwe = dwe_r;
                ack = ($urandom_range(0, 99) < 35);
                err = ($urandom_range(0, 99) < 5);
                rd  = $urandom;

                @(negedge clk);
                exp = '0; oa = 0; oe = 0; done = 0;
                if (owner != 0) begin
                    live = (owner == 1) ? ic : dc;
                    tmo  = (TO != 0) && (age == TO);
                    oa   = live && ack && !err;
                    oe   = live && (err || (tmo && !ack));
                    done = !live || ack || err || tmo;
                end
                if (owner == 1)
                    exp = {ic, ic & istb, 1'b0, 4'hF, ia, 32'h0, oa, oe, 1'b0, 1'b0};
                else if (owner == 2)
                    exp = {dc, dc & dstb, dwe, ds, da, dd, 1'b0, 1'b0, oa, oe};
                check($sformatf("rand%0d_outputs", c), 128'(dut_out()), 128'(exp));
                check($sformatf("rand%0d_rdata", c), 128'({i_dat, d_dat}), 128'({rd, rd}));

                i_fin = (owner == 1) && (oa || oe);
                d_fin = (owner == 2) && (oa || oe);
                if (owner == 0) begin
                    if ((ic && istb) && (dc && dstb)) owner = last_d ? 1 : 2;
                    else if (dc && dstb)              owner = 2;
                    else if (ic && istb)              owner = 1;
                    if (owner != 0) begin
                        last_d = (owner == 2);
                        age = 0;
                    end
                end else if (done) begin
                    owner = 0;
                end else begin
                    age++;
                end
                tick();
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
